// File: rtl/window_gen.sv
// window_gen: builds a 6x6 pixel window from a raster pixel stream using five line
// buffers and a 6x6 shift array; one registered window per accepted in-frame pixel.
`default_nettype none

module window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = 8,
    localparam int CW = $clog2(IMG_W),
    localparam int RW = $clog2(IMG_H)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [PIX_W-1:0] window [0:5][0:5],
    output logic             win_valid,
    output logic [RW-1:0]    win_row,
    output logic [CW-1:0]    win_col,
    output logic             frame_done
);

    localparam logic [CW-1:0] c_last_col = CW'(IMG_W - 1);
    localparam logic [RW-1:0] c_last_row = RW'(IMG_H - 1);
    localparam logic [CW-1:0] c_edge_col = CW'(5);
    localparam logic [RW-1:0] c_edge_row = RW'(5);

    logic [RW-1:0]    r_row;
    logic [CW-1:0]    r_col;
    logic [PIX_W-1:0] r_win [0:5][0:5];
    logic             r_win_valid;
    logic [RW-1:0]    r_win_row;
    logic [CW-1:0]    r_win_col;
    logic             r_frame_done;
    logic [PIX_W-1:0] r_lb [0:4][0:IMG_W-1];

    logic [RW-1:0]    w_r;
    logic [CW-1:0]    w_c;
    logic [PIX_W-1:0] w_lb_rd [0:4];

    // A start-of-frame pixel is (0,0) regardless of where the counters stand.
    assign w_r = sof ? '0 : r_row;
    assign w_c = sof ? '0 : r_col;

    always_comb begin
        for (int k = 0; k < 5; k++) begin
            w_lb_rd[k] = r_lb[k][w_c];
        end
    end

    // r_lb[0] is the most recent line; contents are never reset since they are gated.
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_lb[0][w_c] <= pix_in;
            for (int k = 1; k < 5; k++) begin
                r_lb[k][w_c] <= w_lb_rd[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row        <= '0;
            r_col        <= '0;
            r_win_valid  <= 1'b0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    r_win[i][j] <= '0;
                end
            end
        end else begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            if (pix_valid) begin
                for (int i = 0; i < 6; i++) begin
                    for (int j = 0; j < 5; j++) begin
                        r_win[i][j] <= r_win[i][j+1];
                    end
                end
                for (int i = 0; i < 5; i++) begin
                    r_win[i][5] <= w_lb_rd[4-i];
                end
                r_win[5][5] <= pix_in;

                if (w_r >= c_edge_row && w_c >= c_edge_col) begin
                    r_win_valid <= 1'b1;
                    r_win_row   <= w_r - c_edge_row;
                    r_win_col   <= w_c - c_edge_col;
                end

                if (w_c == c_last_col) begin
                    r_col <= '0;
                    if (w_r == c_last_row) begin
                        r_row        <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_row <= w_r + RW'(1);
                    end
                end else begin
                    r_col <= w_c + CW'(1);
                    r_row <= w_r;
                end
            end
        end
    end

    assign window     = r_win;
    assign win_valid  = r_win_valid;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_window_gen.sv
// tb_window_gen: scoreboard bench for window_gen on an 8x8 frame; the expected window
// is rebuilt from a model image of every accepted pixel.
`default_nettype none

module tb_window_gen;

    localparam int W = 8;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pix_in = '0;
    logic       pix_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] window [0:5][0:5];
    logic       win_valid;
    logic [2:0] win_row;
    logic [2:0] win_col;
    logic       frame_done;

    window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .window     (window),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         valid;
        logic         fd;
        logic [2:0]   wr;
        logic [2:0]   wc;
        logic [287:0] win;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_fail = 0;
    logic [7:0] img [0:H-1][0:W-1];
    int         m_r = 0;
    int         m_c = 0;
    logic [2:0] m_wr = '0;
    logic [2:0] m_wc = '0;
    int         n_valid;
    int         n_fd;
    bit         seen_first;
    logic [7:0] first_w00;
    logic [2:0] first_wr;
    logic [2:0] first_wc;

    task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [287:0] flat_dut();
        logic [287:0] f;
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                f[(i*6+j)*8 +: 8] = window[i][j];
        return f;
    endfunction

    function automatic logic [7:0] pv(input int r, input int c, input bit inv);
        logic [7:0] v;
        v = 8'(r*16 + c);
        return inv ? 8'hFF - v : v;
    endfunction

    task automatic clear_stats();
        n_valid    = 0;
        n_fd       = 0;
        seen_first = 0;
        first_w00  = 8'h5A;
        first_wr   = 3'd7;
        first_wc   = 3'd7;
    endtask

    task automatic step(input bit v, input bit s, input logic [7:0] p);
        exp_t e;
        @(negedge clk);
        pix_valid = v;
        sof       = s;
        pix_in    = p;
        e.valid = 1'b0;
        e.fd    = 1'b0;
        e.win   = '0;
        if (v) begin
            if (s) begin
                m_r = 0;
                m_c = 0;
            end
            img[m_r][m_c] = p;
            if (m_r >= 5 && m_c >= 5) begin
                e.valid = 1'b1;
                m_wr = 3'(m_r - 5);
                m_wc = 3'(m_c - 5);
                for (int i = 0; i < 6; i++)
                    for (int j = 0; j < 6; j++)
                        e.win[(i*6+j)*8 +: 8] = img[m_r-5+i][m_c-5+j];
            end
            if (m_r == H-1 && m_c == W-1) e.fd = 1'b1;
            if (m_c == W-1) begin
                m_c = 0;
                m_r = (m_r == H-1) ? 0 : m_r + 1;
            end else begin
                m_c++;
            end
        end
        e.wr = m_wr;
        e.wc = m_wc;
        sb.push_back(e);

        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("win_valid", 288'(win_valid), 288'(e.valid));
        check("frame_done", 288'(frame_done), 288'(e.fd));
        check("win_row", 288'(win_row), 288'(e.wr));
        check("win_col", 288'(win_col), 288'(e.wc));
        if (e.valid) check("window", flat_dut(), e.win);
        if (win_valid) begin
            n_valid++;
            if (!seen_first) begin
                seen_first = 1;
                first_w00  = window[0][0];
                first_wr   = win_row;
                first_wc   = win_col;
            end
        end
        if (frame_done) n_fd++;
    endtask

    // Pixels k0..k1-1 of the raster; k==0 carries sof. Idle cycles drive sof=1 to show it is ignored.
    task automatic feed(input bit inv, input bit toggle, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            step(1'b1, k == 0, pv(k / W, k % W, inv));
            if (toggle) step(1'b0, 1'b1, 8'hAA);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 288'(win_valid), '0);
        check({tag, "_fd"}, 288'(frame_done), '0);
        check({tag, "_row"}, 288'(win_row), '0);
        check({tag, "_col"}, 288'(win_col), '0);
        check({tag, "_window"}, flat_dut(), '0);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] w00);
        check({tag, "_nvalid"}, 288'(n_valid), 288'(9));
        check({tag, "_nfd"}, 288'(n_fd), 288'(1));
        check({tag, "_first_w00"}, 288'(first_w00), 288'(w00));
        check({tag, "_first_row"}, 288'(first_wr), '0);
        check({tag, "_first_col"}, 288'(first_wc), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #12;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Continuous ramp frame
        clear_stats();
        feed(1'b0, 1'b0, 0, 64);
        step(1'b0, 1'b0, 8'h00);
        check_frame("ramp", 8'h00);

        // Same frame with accept toggling
        clear_stats();
        feed(1'b0, 1'b1, 0, 64);
        check_frame("toggle", 8'h00);

        // Line wrap: stop right after pixel (6,5)
        clear_stats();
        feed(1'b0, 1'b0, 0, 54);
        check("wrap_valid", 288'(win_valid), 288'(1));
        for (int j = 0; j < 6; j++)
            check("wrap_row5", 288'(window[5][j]), 288'(8'h60 + 8'(j)));
        check("wrap_w00", 288'(window[0][0]), 288'(8'h10));
        check("wrap_row", 288'(win_row), 288'(1));
        check("wrap_col", 288'(win_col), 288'(0));
        feed(1'b0, 1'b0, 54, 64);

        // Mid-frame sof at (3,2) then a full frame
        clear_stats();
        feed(1'b0, 1'b0, 0, 27);
        feed(1'b0, 1'b0, 0, 64);
        check_frame("midsof", 8'h00);

        // Asynchronous reset between edges
        clear_stats();
        feed(1'b0, 1'b0, 0, 55);
        #2;
        pix_valid = 1'b0;
        sof       = 1'b0;
        reset     = 1'b0;
        #1;
        check_zero("async_rst");
        m_wr = '0;
        m_wc = '0;
        @(negedge clk);
        reset = 1'b1;
        clear_stats();
        feed(1'b0, 1'b0, 0, 64);
        check_frame("post_rst", 8'h00);

        // Back-to-back frames, second inverted
        feed(1'b0, 1'b0, 0, 64);
        clear_stats();
        feed(1'b1, 1'b0, 0, 64);
        step(1'b0, 1'b0, 8'h00);
        check_frame("inv", 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
